// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer. Fetches one instruction word over
//                a req/ack memory handshake, presents it to the datapath with
//                a one-cycle valid pulse, then selects the next PC when the
//                datapath signals completion. A misaligned target (bit 1 set)
//                parks the sequencer in a sticky error state until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  // Value loaded into the retired-instruction counter on reset.
  parameter logic [31:0] INSTRET_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  branch_ctrl,
  input  logic [31:0] pc_imm,
  input  logic [31:0] alu_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0]  C_BR_ALU   = 2'b00;
  localparam logic [1:0]  C_BR_IMM   = 2'b01;
  localparam logic [31:0] C_LSB_MASK = 32'hFFFF_FFFE;

  state_t      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        err_q;
  logic [31:0] next_pc_d;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection; register-indirect targets have bit 0 forced low.
  always_comb begin
    next_pc_d = pc_plus4;
    case (branch_ctrl)
      C_BR_ALU: next_pc_d = alu_out & C_LSB_MASK;
      C_BR_IMM: next_pc_d = pc_imm;
      default:  next_pc_d = pc_plus4;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      req_q     <= 1'b0;
      addr_q    <= 32'h0000_0000;
      instr_q   <= 32'h0000_0000;
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      instret_q <= INSTRET_RESET;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!req_q) begin
            // New request only when not stalled; ack is meaningless here.
            if (!stall) begin
              req_q  <= 1'b1;
              addr_q <= pc_q;
            end
          end else if (imem_ack) begin
            // Outstanding request completes regardless of stall.
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          valid_q <= 1'b0;
          // exec_done is not trusted during the cycle the word is first shown.
          if (!valid_q && exec_done) begin
            if (next_pc_d[1]) begin
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end else begin
              pc_q      <= next_pc_d;
              instret_q <= instret_q + 32'd1;
              state_q   <= ST_FETCH;
            end
          end
        end
        ST_ERROR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign instret      = instret_q;
  assign misalign_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed + randomized self-checking bench for pc_sequencer.
//                A transaction-level reference (expected pc, instret, instr,
//                error flag) is advanced from the next-PC rules and compared
//                against the DUT on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        exec_done = 1'b0;
  logic [1:0]  branch_ctrl = 2'b10;
  logic [31:0] pc_imm = '0;
  logic [31:0] alu_out = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;
  logic        misalign_err;

  // second instance: wrap-around of pc and instret
  logic        ack2 = 1'b0;
  logic        exec2 = 1'b0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_iv;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_instret;
  logic        w_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  logic [31:0] exp_instr;
  logic        exp_err;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch_ctrl(branch_ctrl),
    .pc_imm(pc_imm), .alu_out(alu_out),
    .pc(pc), .pc_plus4(pc_plus4), .instret(instret),
    .misalign_err(misalign_err)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_RESET(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(ack2), .imem_rdata(imem_rdata),
    .stall(stall), .instr(w_instr), .instr_valid(w_iv),
    .exec_done(exec2), .branch_ctrl(branch_ctrl),
    .pc_imm(pc_imm), .alu_out(alu_out),
    .pc(w_pc), .pc_plus4(w_pc4), .instret(w_instret),
    .misalign_err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference next-PC rule, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [1:0] bc, input logic [31:0] cur,
                                             input logic [31:0] imm, input logic [31:0] alu);
    if (bc == 2'd0) return (alu / 2) * 2;
    if (bc == 2'd1) return imm;
    return cur + 32'd4;
  endfunction

  task automatic check_idle_state(input string tag);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_pc4"}, pc_plus4, exp_pc + 32'd4);
    chk({tag, "_instret"}, instret, exp_instret);
    chk1({tag, "_err"}, misalign_err, exp_err);
  endtask

  // One fetch: optional stall, request, ack after 'lat' extra cycles,
  // then the instr_valid cycle with a spurious exec_done that must be ignored.
  task automatic do_fetch(input logic [31:0] word, input int nstall, input int lat);
    chk1("fetch_idle_req", imem_req, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      chk1("stall_no_req", imem_req, 1'b0);
      chk1("stall_no_valid", instr_valid, 1'b0);
      chk("stall_instr_hold", instr, exp_instr);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    chk1("req_issue", imem_req, 1'b1);
    chk("req_addr", imem_addr, exp_pc);
    check_idle_state("req");
    for (int i = 0; i < lat; i++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1("req_hold", imem_req, 1'b1);
      chk("addr_hold", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    stall      = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_ack  = 1'b0;
    stall     = 1'b0;
    exp_instr = word;
    chk1("ack_req_clr", imem_req, 1'b0);
    chk("instr_latch", instr, word);
    chk1("valid_pulse", instr_valid, 1'b1);
    check_idle_state("ack");
    exec_done   = 1'b1;
    branch_ctrl = 2'($urandom_range(0, 3));
    pc_imm      = $urandom | 32'h2;
    alu_out     = $urandom | 32'h2;
    @(negedge clk);
    exec_done = 1'b0;
    chk1("valid_drop", instr_valid, 1'b0);
    chk("instr_hold", instr, word);
    chk1("exec_no_req", imem_req, 1'b0);
    check_idle_state("early_done");
  endtask

  task automatic do_exec(input logic [1:0] bc, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] nxt;
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      branch_ctrl = 2'($urandom_range(0, 3));
      @(negedge clk);
      check_idle_state("exec_wait");
    end
    nxt = model_next(bc, exp_pc, imm, alu);
    exec_done   = 1'b1;
    branch_ctrl = bc;
    pc_imm      = imm;
    alu_out     = alu;
    @(negedge clk);
    exec_done = 1'b0;
    if (((nxt / 2) % 2) == 1) begin
      exp_err = 1'b1;
    end else begin
      exp_pc      = nxt;
      exp_instret = exp_instret + 32'd1;
    end
    check_idle_state("retire");
    chk1("retire_no_req", imem_req, 1'b0);
    chk1("retire_no_valid", instr_valid, 1'b0);
  endtask

  initial begin
    logic [1:0]  bc;
    logic [31:0] imm;
    logic [31:0] alu;
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    exp_instr   = 32'h0;
    exp_err     = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    check_idle_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Boot: ack on the 2nd request cycle
    do_fetch(32'h0000_0013, 0, 1);
    do_exec(2'b01, 32'h0000_0100, 32'h0);

    // Sequential flow, stalled fetches
    do_fetch($urandom, 5, 2);
    do_exec(2'b10, 32'h0, 32'h0);
    chk("seq_pc_104", pc, 32'h0000_0104);
    do_fetch($urandom, 0, 0);
    chk("seq_addr_104", imem_addr, 32'h0000_0104);
    do_exec(2'b11, 32'h0, 32'h0);
    chk("seq_pc_108", pc, 32'h0000_0108);

    // Jumps
    do_fetch($urandom, 1, 3);
    do_exec(2'b01, 32'h0000_0200, 32'h0);
    chk("jmp_imm_200", pc, 32'h0000_0200);
    do_fetch($urandom, 0, 1);
    do_exec(2'b00, 32'h0, 32'h0000_0301);
    chk("jmp_alu_300", pc, 32'h0000_0300);

    // Randomized aligned program flow
    for (int k = 0; k < 12; k++) begin
      bc  = 2'($urandom_range(0, 3));
      imm = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      do_exec(bc, imm, alu);
    end

    // Reset while a request is outstanding, then a late ack
    stall = 1'b0;
    @(negedge clk);
    chk1("midfetch_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instret", instret, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    exp_instr   = 32'h0;
    exp_err     = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("late_ack_req", imem_req, 1'b0);
    chk1("late_ack_valid", instr_valid, 1'b0);
    chk("late_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;
    do_fetch($urandom, 0, 0);
    do_exec(2'b10, 32'h0, 32'h0);

    // Misaligned target -> sticky error
    do_fetch($urandom, 0, 1);
    do_exec(2'b01, 32'h0000_0202, 32'h0);
    chk1("misalign_flag", misalign_err, 1'b1);
    chk("misalign_pc_kept", pc, 32'h0000_0004);
    for (int i = 0; i < 20; i++) begin
      stall       = 1'($urandom_range(0, 1));
      imem_ack    = 1'($urandom_range(0, 1));
      exec_done   = 1'($urandom_range(0, 1));
      branch_ctrl = 2'b10;
      @(negedge clk);
      chk1("err_no_req", imem_req, 1'b0);
      chk1("err_no_valid", instr_valid, 1'b0);
      check_idle_state("err_hold");
    end
    stall     = 1'b0;
    imem_ack  = 1'b0;
    exec_done = 1'b0;

    // PC and instret wrap on the second instance
    rst_n = 1'b0;
    @(negedge clk);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_pc4", w_pc4, 32'h0);
    chk1("main_rst_err_clr", misalign_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("wrap_req", w_req, 1'b1);
    chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
    ack2       = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    ack2 = 1'b0;
    chk1("wrap_valid", w_iv, 1'b1);
    chk("wrap_instr", w_instr, 32'h1234_5678);
    @(negedge clk);
    exec2       = 1'b1;
    branch_ctrl = 2'b10;
    @(negedge clk);
    exec2 = 1'b0;
    chk("wrap_pc_zero", w_pc, 32'h0);
    chk("wrap_instret_zero", w_instret, 32'h0);
    chk1("wrap_no_err", w_err, 1'b0);
    @(negedge clk);
    chk1("wrap_req2", w_req, 1'b1);
    chk("wrap_addr2", w_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request, registered.
REQ-005 SHALL have port imem_addr  output  32  fetch address, registered.
REQ-006 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  hold-off for issuing a new fetch request.
REQ-009 SHALL have port instr  output  32  latched instruction to the datapath.
REQ-010 SHALL have port instr_valid  output  1  one-cycle pulse when instr is newly latched.
REQ-011 SHALL have port exec_done  input  1  datapath has resolved the current instruction.
REQ-012 SHALL have port branch_ctrl  input  2  next-PC select: 00 ALU_OUT, 01 PC_IMM, 10 PC_4, 11 reserved.
REQ-013 SHALL have port pc_imm  input  32  branch/jump target (PC + immediate).
REQ-014 SHALL have port alu_out  input  32  register-indirect jump target.
REQ-015 SHALL have port pc  output  32  address of the instruction in instr.
REQ-016 SHALL have port pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
REQ-017 SHALL have port instret  output  32  retired-instruction counter.
REQ-018 SHALL have port misalign_err  output  1  sticky misaligned-target error flag.

Function
REQ-019 SHALL implement FSM states BOOT, FETCH, EXEC, ERROR; state is BOOT during reset.
REQ-020 SHALL move BOOT -> FETCH on the first rising edge after rst_n deasserts, with pc = RESET_PC.
REQ-021 SHALL, in FETCH with imem_req=0 and stall=0, set imem_req=1 and imem_addr=pc on the next edge.
REQ-022 SHALL, in FETCH with stall=1 and imem_req=0, issue no request and hold state.
REQ-023 SHALL hold imem_req=1 and imem_addr stable until imem_ack=1 is sampled; stall SHALL NOT withdraw an outstanding request.
REQ-024 SHALL, on an edge with imem_req=1 and imem_ack=1, latch instr=imem_rdata, clear imem_req, set instr_valid=1 and go to EXEC.
REQ-025 SHALL ignore imem_ack whenever imem_req=0.
REQ-026 SHALL drive instr_valid high for exactly the first EXEC cycle; instr holds its value until the next accepted fetch.
REQ-027 SHALL ignore exec_done in FETCH and in the EXEC cycle where instr_valid=1.
REQ-028 SHALL, on exec_done=1 in EXEC, select the next PC: 00 -> {alu_out[31:1],1'b0}; 01 -> pc_imm; 10 -> pc+4; 11 -> pc+4.
REQ-029 SHALL, when the selected next PC has bit1 set, keep pc unchanged, set misalign_err=1 and go to ERROR; instret SHALL NOT increment.
REQ-030 SHALL otherwise load pc with the next PC, increment instret by 1 (wrapping 32'hFFFF_FFFF -> 0) and go to FETCH.
REQ-031 SHALL, in ERROR, hold imem_req=0, instr_valid=0, pc and instret; exit only via reset.
REQ-032 SHALL wrap all PC arithmetic modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-033 SHALL give a minimum loop of 4 cycles per instruction: request edge, ack edge, instr_valid cycle, exec_done edge.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_valid=0, instret=0, misalign_err=0.
REQ-035 SHALL, on reset asserted mid-fetch or mid-execute, abandon the transaction without waiting for imem_ack; a late ack after reset release is ignored per REQ-025.

Verification
REQ-036 SHALL cover boot: release rst_n, stall=0, ack on 2nd request cycle with rdata=32'h0000_0013 -> imem_addr=0, instr=32'h13, instr_valid one-cycle pulse.
REQ-037 SHALL cover sequential: pc=0x100, exec_done with branch_ctrl=10 -> pc=0x104, instret+1, next imem_addr=0x104; branch_ctrl=11 gives same result.
REQ-038 SHALL cover jumps: branch_ctrl=01, pc_imm=0x200 -> pc=0x200; branch_ctrl=00, alu_out=0x301 -> pc=0x300.
REQ-039 SHALL cover misalignment: branch_ctrl=01, pc_imm=0x202 -> misalign_err=1, pc unchanged, imem_req stays 0 for 20 cycles, instret unchanged.
REQ-040 SHALL cover stall/handshake: stall=1 in FETCH for 5 cycles -> no imem_req; stall raised after imem_req=1 -> request and address held until ack.
REQ-041 SHALL cover reset mid-fetch and wrap: rst_n low while imem_req=1 -> imem_req=0 at once; pc=0xFFFF_FFFC with PC_4 -> pc=0; instret preset to 0xFFFF_FFFF -> 0.
